mult8x8_sequencer: RTL and testbench

- Sequential 8x8 unsigned multiplier engine.
- Computes a 16-bit product in four shift-add steps, using one combinational 4x4 partial-product multiplier.
- Sits directly upstream of the 16-bit output register: drives its datain, clk_ena and sclr_n.
- One product per start request; the result is written into the downstream register on the done cycle.

---
 rtl/mult8x8_sequencer_pkg.sv | 27 ++
 rtl/mult8x8_sequencer_if.sv | 30 +++
 rtl/mult8x8_sequencer_mult4x4.sv | 13 +
 rtl/mult8x8_sequencer.sv | 135 +++++++++++++
 tb/tb_mult8x8_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult8x8_sequencer_pkg.sv
// Shared constants, state encoding and shift amounts for the 8x8 shift-add multiplier.
// Included first; everything else imports mult_pkg::*.
package mult_pkg;

   localparam int DATA_W = 8;
   localparam int PROD_W = 2 * DATA_W;
   localparam int NIB_W  = DATA_W / 2;

   localparam logic [3:0] SHIFT_0 = 4'd0;
   localparam logic [3:0] SHIFT_4 = 4'd4;
   localparam logic [3:0] SHIFT_8 = 4'd8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LSB  = 3'd1,
      MID1 = 3'd2,
      MID2 = 3'd3,
      MSB  = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == LSB) || (s == MID1) || (s == MID2) || (s == MSB);
   endfunction

endpackage

// File: rtl/mult8x8_sequencer_if.sv
// Request/result bundle between a requester and the multiplier sequencer.
// The err signal exists only when MULT_SEQ_ERR_EN is defined.
interface mult8x8_sequencer_if
   import mult_pkg::*;
   ();

   logic              start;
   logic [DATA_W-1:0] dataa;
   logic [DATA_W-1:0] datab;
   logic              busy;
   logic              done_flag;
   logic [PROD_W-1:0] product_out;
   logic              reg_ena;
   logic              reg_sclr_n;
   logic [2:0]        state_out;
`ifdef MULT_SEQ_ERR_EN
   logic              err;

   modport master (output start, dataa, datab,
                   input  busy, done_flag, product_out, reg_ena, reg_sclr_n, state_out, err);
   modport slave  (input  start, dataa, datab,
                   output busy, done_flag, product_out, reg_ena, reg_sclr_n, state_out, err);
`else
   modport master (output start, dataa, datab,
                   input  busy, done_flag, product_out, reg_ena, reg_sclr_n, state_out);
   modport slave  (input  start, dataa, datab,
                   output busy, done_flag, product_out, reg_ena, reg_sclr_n, state_out);
`endif

endinterface

// File: rtl/mult8x8_sequencer_mult4x4.sv
// Combinational unsigned NIB_W x NIB_W -> DATA_W partial-product multiplier.
// Zero latency, no flow control.
module mult4x4
   import mult_pkg::*;
(
   input  logic [NIB_W-1:0]  a,
   input  logic [NIB_W-1:0]  b,
   output logic [DATA_W-1:0] p
);

   assign p = DATA_W'(a) * DATA_W'(b);

endmodule

// File: rtl/mult8x8_sequencer.sv
// Sequential 8x8 unsigned multiplier: 4 shift-add steps, result on a one-cycle DONE pulse 5 edges after acceptance.
// start is only sampled in IDLE; with MULT_SEQ_ERR_EN a start while busy aborts into ERR and sets a sticky err.
module mult8x8_sequencer
   import mult_pkg::*;
(
   input  logic                 clk,
   input  logic                 sclr,
   mult8x8_sequencer_if.slave   bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [PROD_W-1:0] acc_q, acc_d;

   logic [NIB_W-1:0]  op_a, op_b;
   logic [DATA_W-1:0] pp;
   logic [3:0]        shamt;
   logic [PROD_W-1:0] pp_shifted;

   // Each step picks one nibble pair and its weight in the final product.
   always_comb begin
      op_a  = a_q[NIB_W-1:0];
      op_b  = b_q[NIB_W-1:0];
      shamt = SHIFT_0;
      case (state_q)
         MID1: begin
            op_a  = a_q[DATA_W-1:NIB_W];
            shamt = SHIFT_4;
         end
         MID2: begin
            op_b  = b_q[DATA_W-1:NIB_W];
            shamt = SHIFT_4;
         end
         MSB: begin
            op_a  = a_q[DATA_W-1:NIB_W];
            op_b  = b_q[DATA_W-1:NIB_W];
            shamt = SHIFT_8;
         end
         default: ;
      endcase
   end

   mult4x4 u_pp (
      .a (op_a),
      .b (op_b),
      .p (pp)
   );

   assign pp_shifted = PROD_W'(pp) << shamt;

`ifdef MULT_SEQ_ERR_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
`ifdef MULT_SEQ_ERR_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LSB;
               a_d     = bus.dataa;
               b_d     = bus.datab;
               acc_d   = '0;
`ifdef MULT_SEQ_ERR_EN
               err_d   = 1'b0;
`endif
            end
         end
         LSB: begin
            acc_d   = pp_shifted;
            state_d = MID1;
         end
         MID1: begin
            acc_d   = acc_q + pp_shifted;
            state_d = MID2;
         end
         MID2: begin
            acc_d   = acc_q + pp_shifted;
            state_d = MSB;
         end
         MSB: begin
            acc_d   = acc_q + pp_shifted;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
`ifdef MULT_SEQ_ERR_EN
      // A second request mid-operation abandons the current product.
      if (is_busy(state_q) && bus.start) begin
         state_d = ERR;
         acc_d   = acc_q;
         err_d   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
`ifdef MULT_SEQ_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
`ifdef MULT_SEQ_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   assign bus.busy        = is_busy(state_q);
   assign bus.done_flag   = (state_q == DONE);
   assign bus.reg_ena     = (state_q == DONE);
   assign bus.product_out = acc_q;
   // Downstream register is cleared on reset and again on every accepted request.
   assign bus.reg_sclr_n  = !(sclr || ((state_q == IDLE) && bus.start));
   assign bus.state_out   = state_q;
`ifdef MULT_SEQ_ERR_EN
   assign bus.err         = err_q;
`endif

endmodule

// File: tb/tb_mult8x8_sequencer.sv
// Directed-vector bench for mult8x8_sequencer; honours MULT_SEQ_ERR_EN for the restart scenario.
module tb_mult8x8_sequencer;

   logic clk;
   logic sclr;
   int   vectors;
   int   miscompares;

   mult8x8_sequencer_if mif ();

   mult8x8_sequencer dut (
      .clk  (clk),
      .sclr (sclr),
      .bus  (mif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      sclr = 1'b1;
      mif.start = 1'b1;
      mif.dataa = 8'h77;
      mif.datab = 8'h99;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (mif.state_out !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_state got %0d want 0", mif.state_out);
      end
      vectors++;
      if ({mif.busy, mif.done_flag, mif.reg_ena} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_flags busy/done/ena got %b want 000", {mif.busy, mif.done_flag, mif.reg_ena});
      end
      vectors++;
      if (mif.product_out !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_product got %h want 0000", mif.product_out);
      end
      vectors++;
      if (mif.reg_sclr_n !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_sclr_n got %b want 0", mif.reg_sclr_n);
      end
`ifdef MULT_SEQ_ERR_EN
      vectors++;
      if (mif.err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_err got %b want 0", mif.err);
      end
`endif
      mif.start = 1'b0;
      sclr = 1'b0;
      #1;
      vectors++;
      if (mif.reg_sclr_n !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_sclr_n got %b want 1", mif.reg_sclr_n);
      end
   endtask

   task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp, input string name);
      logic [6:0]  busy_s, done_s, ena_s, sclrn_s;
      logic [15:0] prod;
      prod = 16'hxxxx;
      @(negedge clk);
      mif.dataa = a;
      mif.datab = b;
      mif.start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) begin
            mif.start = 1'b0;
            mif.dataa = ~a;
            mif.datab = ~b;
         end
         #1;
         busy_s[i]  = mif.busy;
         done_s[i]  = mif.done_flag;
         ena_s[i]   = mif.reg_ena;
         sclrn_s[i] = mif.reg_sclr_n;
         if (i == 5) prod = mif.product_out;
      end
      vectors++;
      if (busy_s !== 7'b0011110) begin
         miscompares++;
         $display("FAIL %s busy_seq got %b want 0011110", name, busy_s);
      end
      vectors++;
      if (done_s !== 7'b0100000) begin
         miscompares++;
         $display("FAIL %s done_seq got %b want 0100000", name, done_s);
      end
      vectors++;
      if (ena_s !== 7'b0100000) begin
         miscompares++;
         $display("FAIL %s ena_seq got %b want 0100000", name, ena_s);
      end
      vectors++;
      if (sclrn_s !== 7'b1111110) begin
         miscompares++;
         $display("FAIL %s sclr_n_seq got %b want 1111110", name, sclrn_s);
      end
      vectors++;
      if (prod !== exp) begin
         miscompares++;
         $display("FAIL %s product got %h want %h", name, prod, exp);
      end
   endtask

   task automatic test_products();
      run_mult(8'h12, 8'h34, 16'h03A8, "p12x34");
      run_mult(8'hFF, 8'hFF, 16'hFE01, "pFFxFF");
      run_mult(8'h80, 8'h02, 16'h0100, "p80x02");
      run_mult(8'h00, 8'hAB, 16'h0000, "p00xAB");
   endtask

   task automatic test_sclr_abort();
      int dones;
      dones = 0;
      @(negedge clk);
      mif.dataa = 8'h55;
      mif.datab = 8'hAA;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (mif.state_out !== 3'd2) begin
         miscompares++;
         $display("FAIL abort_in_mid1 state got %0d want 2", mif.state_out);
      end
      sclr = 1'b1;
      #1;
      vectors++;
      if (mif.reg_sclr_n !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_sclr_n got %b want 0", mif.reg_sclr_n);
      end
      @(negedge clk);
      sclr = 1'b0;
      #1;
      vectors++;
      if ({mif.state_out, mif.busy} !== 4'b0000) begin
         miscompares++;
         $display("FAIL abort_idle state/busy got %0d/%b want 0/0", mif.state_out, mif.busy);
      end
      vectors++;
      if (mif.product_out !== 16'h0000) begin
         miscompares++;
         $display("FAIL abort_acc got %h want 0000", mif.product_out);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         #1;
         if (mif.done_flag === 1'b1) dones++;
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("FAIL abort_no_done got %0d pulses want 0", dones);
      end
      run_mult(8'h0F, 8'h0F, 16'h00E1, "after_abort");
   endtask

`ifndef MULT_SEQ_ERR_EN
   task automatic test_back_to_back();
      int pulses;
      int last;
      logic idle_seen;
      pulses = 0;
      last = -1;
      idle_seen = 1'b0;
      @(negedge clk);
      mif.dataa = 8'h03;
      mif.datab = 8'h05;
      mif.start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 6) mif.dataa = 8'h04;
         #1;
         if (mif.done_flag === 1'b1) begin
            vectors++;
            if (mif.product_out !== ((pulses == 0) ? 16'h000F : 16'h0014)) begin
               miscompares++;
               $display("FAIL b2b_product pulse %0d got %h want %h", pulses, mif.product_out,
                        (pulses == 0) ? 16'h000F : 16'h0014);
            end
            vectors++;
            if (i != ((last < 0) ? 5 : last + 6)) begin
               miscompares++;
               $display("FAIL b2b_spacing pulse at cycle %0d want %0d", i, (last < 0) ? 5 : last + 6);
            end
            last = i;
            pulses++;
         end
      end
      vectors++;
      if (pulses != 3) begin
         miscompares++;
         $display("FAIL b2b_count got %0d want 3", pulses);
      end
      mif.start = 1'b0;
      for (int i = 0; i < 10 && !idle_seen; i++) begin
         @(negedge clk);
         #1;
         if (mif.state_out === 3'd0) idle_seen = 1'b1;
      end
      vectors++;
      if (!idle_seen) begin
         miscompares++;
         $display("FAIL b2b_drain state got %0d want 0", mif.state_out);
      end
   endtask
`endif

   task automatic test_restart_in_mid2();
      logic [8:0]  done_s;
      logic [15:0] prod;
      logic [2:0]  st4;
      prod = 16'hxxxx;
      st4 = 3'bxxx;
      @(negedge clk);
      mif.dataa = 8'h12;
      mif.datab = 8'h34;
      mif.start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) mif.start = 1'b0;
         if (i == 3) mif.start = 1'b1;
         if (i == 4) mif.start = 1'b0;
         #1;
         done_s[i] = mif.done_flag;
         if (i == 5) prod = mif.product_out;
         if (i == 4) st4 = mif.state_out;
`ifdef MULT_SEQ_ERR_EN
         if (i == 4) begin
            vectors++;
            if (mif.err !== 1'b1) begin
               miscompares++;
               $display("FAIL err_set got %b want 1", mif.err);
            end
         end
`endif
      end
`ifdef MULT_SEQ_ERR_EN
      vectors++;
      if (st4 !== 3'd6) begin
         miscompares++;
         $display("FAIL err_state got %0d want 6", st4);
      end
      vectors++;
      if (done_s !== 9'b0) begin
         miscompares++;
         $display("FAIL err_no_done got %b want 000000000", done_s);
      end
      vectors++;
      if ({mif.err, mif.state_out} !== 4'b1000) begin
         miscompares++;
         $display("FAIL err_sticky err/state got %b/%0d want 1/0", mif.err, mif.state_out);
      end
      run_mult(8'h0F, 8'h0F, 16'h00E1, "after_err");
      vectors++;
      if (mif.err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear got %b want 0", mif.err);
      end
`else
      vectors++;
      if (st4 !== 3'd4) begin
         miscompares++;
         $display("FAIL restart_ignored state got %0d want 4", st4);
      end
      vectors++;
      if (done_s !== 9'b000100000) begin
         miscompares++;
         $display("FAIL restart_done_seq got %b want 000100000", done_s);
      end
      vectors++;
      if (prod !== 16'h03A8) begin
         miscompares++;
         $display("FAIL restart_product got %h want 03a8", prod);
      end
`endif
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      sclr = 1'b1;
      mif.start = 1'b0;
      mif.dataa = 8'h00;
      mif.datab = 8'h00;
      test_reset();
      test_products();
      test_sclr_abort();
`ifndef MULT_SEQ_ERR_EN
      test_back_to_back();
`endif
      test_restart_in_mid2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
